// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix result path: FSM states, frame phases, and
// the word-count helper that clamps N before squaring.
package matrix_pkg;

  localparam int         ADDR_W_DEF = 4;
  localparam int         DATA_W_DEF = 32;
  localparam int         MAX_N      = 4;
  localparam logic [7:0] FRAME_HDR  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_PAY,
    PH_CHK
  } phase_t;

  function automatic logic [4:0] word_count(input logic [3:0] n);
    logic [4:0] nc;
    nc = (n > 4'(MAX_N)) ? 5'(MAX_N) : {1'b0, n};
    return nc * nc;
  endfunction

endpackage

// File: rtl/result_sender_word_serializer.sv
// Word-wide shift register for result_sender: loads a result word, then shifts it left
// one byte at a time so the most significant byte is always on top.
module word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        top_byte,
  output logic              last
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] sreg;
  logic [BIDX_W-1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      byte_idx <= '0;
    end else if (load) begin
      sreg     <= din;
      byte_idx <= '0;
    end else if (shift) begin
      sreg     <= sreg << 8;
      byte_idx <= byte_idx + BIDX_W'(1);
    end
  end

  assign top_byte = sreg[DATA_W-1 -: 8];
  assign last     = (byte_idx == BIDX_W'(BYTES - 1));

endmodule

// File: rtl/result_sender.sv
// Streams N x N result words (row-major, MSB first) to uart_tx over start/busy.
// Optional framing (header 0xA5 + XOR checksum) when RESULT_SENDER_FRAME_EN is defined.
//
//   state     | meaning
//   IDLE      | waiting for start
//   FETCH     | result_addr presented to memory
//   LATCH     | read data captured into serializer
//   SEND      | waiting for tx_busy low, then pulse tx_start
//   WAIT_ACK  | waiting for uart_tx to go busy
//   WAIT_DONE | waiting for uart_tx to finish the byte
//   FINISH    | done pulse
module result_sender
  import matrix_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] result_addr,
  input  logic [DATA_W-1:0] result_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  state_t     state, state_nxt;
  logic [4:0] word_cnt, word_idx;
  logic       ser_load, ser_shift, ser_last, word_inc;
  logic [7:0] ser_byte;
  logic       more_words;

  assign more_words = (word_idx + 5'd1) < word_cnt;

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .din      (result_data),
    .top_byte (ser_byte),
    .last     (ser_last)
  );

`ifdef RESULT_SENDER_FRAME_EN
  phase_t     phase, phase_nxt;
  logic [7:0] chk;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_PAY;
      chk   <= '0;
    end else begin
      phase <= phase_nxt;
      if (state == IDLE && start) chk <= '0;
      else if (tx_start && phase == PH_PAY) chk <= chk ^ ser_byte;
    end
  end

  always_comb begin
    case (phase)
      PH_HDR:  tx_data = FRAME_HDR;
      PH_CHK:  tx_data = chk;
      default: tx_data = ser_byte;
    endcase
  end
`else
  assign tx_data = ser_byte;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        word_cnt <= word_count(matrix_size);
        word_idx <= '0;
      end else if (word_inc) begin
        word_idx <= word_idx + 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    word_inc  = 1'b0;
`ifdef RESULT_SENDER_FRAME_EN
    phase_nxt = phase;
`endif
    case (state)
      IDLE: begin
        if (start) begin
`ifdef RESULT_SENDER_FRAME_EN
          phase_nxt = PH_HDR;
          state_nxt = SEND;
`else
          state_nxt = (word_count(matrix_size) == 5'd0) ? FINISH : FETCH;
`endif
        end
      end
      FETCH: state_nxt = LATCH;
      LATCH: begin
        ser_load  = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef RESULT_SENDER_FRAME_EN
          case (phase)
            PH_HDR: begin
              if (word_cnt == 5'd0) begin
                phase_nxt = PH_CHK;
                state_nxt = SEND;
              end else begin
                phase_nxt = PH_PAY;
                state_nxt = FETCH;
              end
            end
            PH_PAY: begin
              if (!ser_last) begin
                ser_shift = 1'b1;
                state_nxt = SEND;
              end else if (more_words) begin
                word_inc  = 1'b1;
                state_nxt = FETCH;
              end else begin
                phase_nxt = PH_CHK;
                state_nxt = SEND;
              end
            end
            default: state_nxt = FINISH;
          endcase
`else
          if (!ser_last) begin
            ser_shift = 1'b1;
            state_nxt = SEND;
          end else if (more_words) begin
            word_inc  = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = FINISH;
          end
`endif
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign result_addr = ADDR_W'(word_idx);
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

endmodule
